// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests words from instruction memory, holds each one
// for the datapath until it retires, then steps the PC (sequential, branch or jump).
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic [31:0] cycles,
    output logic [31:0] instructions
);

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        HALT
    } state_t;

    localparam logic [5:0] OPC_HLT = 6'b111111;

    state_t      state;
    state_t      state_next;
    logic        running;
    logic        fetch_hit;
    logic        is_hlt;
    logic        retire;
    logic        pc_load;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    assign opcode    = instr[31:26];
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign is_hlt    = (opcode == OPC_HLT);

    // running holds the request off until the first edge after reset release
    assign fetch_hit = (state == FETCH) && running && imem_ack;
    assign retire    = (state == ISSUE) && (is_hlt || exec_done);
    assign pc_load   = (state == ISSUE) && !is_hlt && exec_done;

    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (fetch_hit) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (is_hlt) begin
                    state_next = HALT;
                end else if (exec_done) begin
                    state_next = FETCH;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            FETCH:   imem_req    = running;
            ISSUE:   instr_valid = 1'b1;
            HALT:    halted      = 1'b1;
            default: imem_req    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running      <= 1'b0;
            pc           <= RESET_PC;
            instr        <= 32'h0000_0000;
            cycles       <= 32'h0000_0000;
            instructions <= 32'h0000_0000;
        end else begin
            running <= 1'b1;
            if (fetch_hit) begin
                instr <= imem_rdata;
            end
            if (pc_load) begin
                pc <= next_pc;
            end
            if (state != HALT) begin
                cycles <= cycles + 32'd1;
            end
            if (retire) begin
                instructions <= instructions + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fetch timing, next-PC selection, halt, counters
// and asynchronous reset, checked against hand-computed values.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        exec_done;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic [31:0] cycles;
    logic [31:0] instructions;

    int          total_checks;
    int          bad_checks;
    logic [31:0] exp_pc;
    logic [31:0] exp_cycles;
    logic [31:0] exp_instrs;
    logic        model_halted;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .branch       (branch),
        .jump         (jump),
        .zero         (zero),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .halted       (halted),
        .cycles       (cycles),
        .instructions (instructions)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock; the cycle counter model advances only while running and not halted
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n && !model_halted) exp_cycles++;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_pc"}, pc, exp_pc);
        checkOutput({tag, "_pc4"}, pc_plus4, exp_pc + 32'd4);
        checkOutput({tag, "_cycles"}, cycles, exp_cycles);
        checkOutput({tag, "_instrs"}, instructions, exp_instrs);
        checkOutput({tag, "_halted"}, 32'(halted), 32'(model_halted));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pc"}, pc, 32'h0);
        checkOutput({tag, "_instr"}, instr, 32'h0);
        checkOutput({tag, "_valid"}, 32'(instr_valid), 32'h0);
        checkOutput({tag, "_req"}, 32'(imem_req), 32'h0);
        checkOutput({tag, "_halted"}, 32'(halted), 32'h0);
        checkOutput({tag, "_cycles"}, cycles, 32'h0);
        checkOutput({tag, "_instrs"}, instructions, 32'h0);
    endtask

    // Async reset between edges, optionally with an ack left pending across release
    task automatic resetDut(input string tag, input logic ack_pending);
        rst_n = 1'b0;
        #1;
        checkResetValues({tag, "_async"});
        imem_ack   = ack_pending;
        imem_rdata = 32'hA5A5_A5A5;
        exec_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        exp_pc       = 32'h0;
        exp_cycles   = 32'h0;
        exp_instrs   = 32'h0;
        model_halted = 1'b0;
        checkOutput({tag, "_req_pre"}, 32'(imem_req), 32'h0);
        tick();
        imem_ack = 1'b0;
        checkOutput({tag, "_req_first"}, 32'(imem_req), 32'h1);
        checkOutput({tag, "_addr_first"}, imem_addr, 32'h0);
        checkOutput({tag, "_valid_first"}, 32'(instr_valid), 32'h0);
        checkOutput({tag, "_instr_first"}, instr, 32'h0);
        checkState({tag, "_first"});
    endtask

    task automatic fetchInstr(input string tag, input int waits, input logic [31:0] word);
        imem_ack = 1'b0;
        for (int i = 0; i < waits; i++) begin
            checkOutput({tag, "_wreq"}, 32'(imem_req), 32'h1);
            checkOutput({tag, "_waddr"}, imem_addr, exp_pc);
            checkOutput({tag, "_wvalid"}, 32'(instr_valid), 32'h0);
            tick();
        end
        exec_done  = 1'b0;
        checkOutput({tag, "_addr"}, imem_addr, exp_pc);
        checkOutput({tag, "_req"}, 32'(imem_req), 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h1234_5678;
        checkOutput({tag, "_valid"}, 32'(instr_valid), 32'h1);
        checkOutput({tag, "_instr"}, instr, word);
        checkOutput({tag, "_opcode"}, 32'(opcode), 32'(word[31:26]));
        checkOutput({tag, "_ireq"}, 32'(imem_req), 32'h0);
        checkState({tag, "_issue"});
    endtask

    // Retire the held instruction with the given control inputs and expected target
    task automatic applyStimulus(input string tag, input logic br, input logic jp,
                                 input logic z, input logic [31:0] exp_next);
        branch    = br;
        jump      = jp;
        zero      = z;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        zero      = 1'b0;
        exp_pc    = exp_next;
        exp_instrs++;
        checkOutput({tag, "_valid"}, 32'(instr_valid), 32'h0);
        checkOutput({tag, "_req"}, 32'(imem_req), 32'h1);
        checkState({tag, "_ret"});
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        model_halted = 1'b0;
        exp_pc       = 32'h0;
        exp_cycles   = 32'h0;
        exp_instrs   = 32'h0;
        rst_n        = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        exec_done    = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        zero         = 1'b0;
        #12;
        resetDut("rst0", 1'b0);

        // zero-wait fetch, exec_done one cycle after instr_valid
        fetchInstr("zw", 0, 32'h2001_0005);
        checkOutput("zw_op", 32'(opcode), 32'h08);
        tick();
        checkOutput("zw_hold_instr", instr, 32'h2001_0005);
        checkOutput("zw_hold_valid", 32'(instr_valid), 32'h1);
        applyStimulus("zw", 1'b0, 1'b0, 1'b0, 32'h4);

        // wait states with exec_done noise in FETCH, then an ack ignored in ISSUE
        exec_done = 1'b1;
        fetchInstr("ws", 3, 32'h0000_0000);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        checkOutput("ws_ack_ignored", instr, 32'h0000_0000);
        checkOutput("ws_valid_held", 32'(instr_valid), 32'h1);
        applyStimulus("ws", 1'b0, 1'b0, 1'b0, 32'h8);

        fetchInstr("s8", 1, 32'h0000_0000);
        applyStimulus("s8", 1'b0, 1'b0, 1'b0, 32'hC);
        fetchInstr("sc", 0, 32'h0000_0000);
        applyStimulus("sc", 1'b0, 1'b0, 1'b0, 32'h10);

        // branch taken backwards, then the same branch not taken
        fetchInstr("bt", 0, 32'h1000_FFFE);
        applyStimulus("bt", 1'b1, 1'b0, 1'b1, 32'h0C);
        fetchInstr("bc", 2, 32'h0000_0000);
        applyStimulus("bc", 1'b0, 1'b0, 1'b0, 32'h10);
        fetchInstr("bn", 0, 32'h1000_FFFE);
        applyStimulus("bn", 1'b1, 1'b0, 1'b0, 32'h14);

        // jump, then jump overriding a taken branch
        fetchInstr("j1", 0, 32'h0800_0010);
        applyStimulus("j1", 1'b0, 1'b1, 1'b0, 32'h40);
        fetchInstr("jp", 1, 32'h0800_0100);
        applyStimulus("jp", 1'b1, 1'b1, 1'b1, 32'h400);

        // reset during a FETCH wait
        fetchInstr("rf", 2, 32'h0000_0000);
        resetDut("rstf", 1'b0);

        // backward branch from 0 wraps to the top of the address space and back
        fetchInstr("wr", 0, 32'h1000_FFFE);
        applyStimulus("wr", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checkOutput("wr_pc4", pc_plus4, 32'h0000_0000);
        fetchInstr("wt", 0, 32'h0000_0000);
        applyStimulus("wt", 1'b0, 1'b0, 1'b0, 32'h0);

        // reset during ISSUE with an ack still pending across release
        fetchInstr("ri", 0, 32'h2001_0005);
        resetDut("rsti", 1'b1);

        // halt retires without exec_done and freezes everything
        fetchInstr("ht", 1, 32'hFC00_0000);
        checkOutput("ht_op", 32'(opcode), 32'h3F);
        tick();
        exp_instrs++;
        model_halted = 1'b1;
        checkOutput("ht_valid", 32'(instr_valid), 32'h0);
        checkOutput("ht_req", 32'(imem_req), 32'h0);
        checkState("ht_enter");
        exec_done  = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h2001_0005;
        repeat (4) tick();
        exec_done = 1'b0;
        imem_ack  = 1'b0;
        checkOutput("ht_instr", instr, 32'hFC00_0000);
        checkOutput("ht_valid2", 32'(instr_valid), 32'h0);
        checkOutput("ht_req2", 32'(imem_req), 32'h0);
        checkState("ht_frozen");

        resetDut("rsth", 1'b0);
        fetchInstr("post", 0, 32'h0000_0000);
        applyStimulus("post", 1'b0, 1'b0, 1'b0, 32'h4);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
